// File: rtl/md_phase_scheduler_pkg.sv
// md_phase_scheduler_pkg: shared state encoding for the MD timestep phase scheduler.
package md_phase_scheduler_pkg;
  typedef enum logic [2:0] {
    st_idle,
    st_load,
    st_force,
    st_drain,
    st_motion,
    st_check
  } state_t;
endpackage

// File: rtl/phase_watchdog.sv
// phase_watchdog: counts cycles spent in one state and pulses expire on the LIMIT-th cycle (LIMIT=0 disables).
module phase_watchdog #(
  parameter int unsigned LIMIT = 65535
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic en,
  output logic expire
);
  logic [31:0] cnt, cur;
  // clear marks the first cycle of a new state, so that cycle counts as zero
  assign cur = clear ? '0 : cnt;
  assign expire = en && (LIMIT != 0) && (cur == LIMIT - 1);
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) cnt <= '0;
    else cnt <= en ? cur + 32'd1 : '0;
  end
endmodule

// File: rtl/md_phase_scheduler.sv
// md_phase_scheduler: sequences LOAD/FORCE/DRAIN/MOTION/CHECK across all PEs for a run of timesteps.
module md_phase_scheduler
  import md_phase_scheduler_pkg::*;
#(
  parameter int          NUM_PE         = 8,
  parameter int          ITER_WIDTH     = 16,
  parameter int unsigned TIMEOUT_CYCLES = 65535
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [ITER_WIDTH-1:0] num_iterations,
  input  logic [NUM_PE-1:0]     pe_reading_done,
  input  logic [NUM_PE-1:0]     pe_back_pressure,
  input  logic [NUM_PE-1:0]     pe_all_buffer_empty,
  input  logic [NUM_PE-1:0]     pe_all_ref_wb_issued,
  input  logic                  ring_idle,
  input  logic                  mu_done,
  output logic                  phase,
  output logic                  pause_reading,
  output logic                  reading_particle_num,
  output logic                  mu_start,
  output logic                  busy,
  output logic [ITER_WIDTH-1:0] iter_count,
  output logic                  run_done,
  output logic                  timeout_err
);
  state_t state, state_d;
  logic [NUM_PE-1:0] sticky;
  logic [ITER_WIDTH-1:0] num_lat, iter_nxt;
  logic expire;
  assign iter_nxt = iter_count + ITER_WIDTH'(1);
  phase_watchdog #(.LIMIT(TIMEOUT_CYCLES)) u_wd (
    .clk(clk),
    .rst(rst),
    .clear(state != state_d),
    .en(state inside {st_force, st_drain, st_motion}),
    .expire(expire)
  );
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= st_idle;
      state_d <= st_idle;
      phase <= 1'b0;
      pause_reading <= 1'b1;
      reading_particle_num <= 1'b0;
      mu_start <= 1'b0;
      busy <= 1'b0;
      iter_count <= '0;
      run_done <= 1'b0;
      timeout_err <= 1'b0;
      sticky <= '0;
      num_lat <= '0;
    end else begin
      state_d <= state;
      reading_particle_num <= 1'b0;
      mu_start <= 1'b0;
      run_done <= 1'b0;
      pause_reading <= 1'b1;
      if (expire) begin
        state <= st_idle;
        busy <= 1'b0;
        timeout_err <= 1'b1;
      end else begin
        case (state)
          st_idle: if (start) begin
            iter_count <= '0;
            timeout_err <= 1'b0;
            num_lat <= num_iterations;
            if (num_iterations == '0) run_done <= 1'b1;
            else begin
              state <= st_load;
              busy <= 1'b1;
              reading_particle_num <= 1'b1;
            end
          end
          // reading_particle_num is high only on the first LOAD cycle, so its low value marks the second
          st_load: if (!reading_particle_num) begin
            state <= st_force;
            sticky <= '0;
          end
          st_force: begin
            sticky <= sticky | pe_reading_done;
            if (&(sticky | pe_reading_done)) state <= st_drain;
            else pause_reading <= |pe_back_pressure;
          end
          st_drain: if (&pe_all_buffer_empty & &pe_all_ref_wb_issued & ring_idle) begin
            state <= st_motion;
            mu_start <= 1'b1;
          end
          st_motion: if (mu_done) begin
            state <= st_check;
            phase <= ~phase;
          end
          st_check: begin
            iter_count <= iter_nxt;
            if (iter_nxt == num_lat) begin
              state <= st_idle;
              busy <= 1'b0;
              run_done <= 1'b1;
            end else begin
              state <= st_load;
              reading_particle_num <= 1'b1;
            end
          end
          default: state <= st_idle;
        endcase
      end
    end
  end
endmodule
